match_ctrl: RTL and testbench
=============================

// Module: match_ctrl
// PURPOSE
//  Match sequencer for the two-player pong game. Runs the top-level game FSM
//  (ready/setting/serve/play/game-over) and owns scores, the countdown timer and
//  user settings (win score, ball speed, time limit). Drives ball reset/enable
//  and game_over for the ball, pixel_gen and display_text datapath.
//  Sits in top between the one_pulse button outputs, the ball block and the renderers.
// PARAMETERS
//  FRAMES_PER_SEC  60   frame_tick pulses per game second
//  SERVE_FRAMES    60   frame_ticks the ball is held before each serve
//  OVER_FRAMES     180  frame_ticks game-over screen is held before auto-return
//  DEF_WIN         5    win_score after reset (legal 1..9)
//  DEF_SPEED       2    ball_speed after reset (legal 1..15)
//  DEF_TIME        60   time_limit in seconds after reset (legal 10..99)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous active-high reset
//  frame_tick   in   1  1-cycle pulse per video frame (refresh_tick)
//  enter_pulse  in   1  1-cycle debounced enter press
//  up_pulse     in   1  1-cycle debounced up press (player 1)
//  down_pulse   in   1  1-cycle debounced down press (player 1)
//  miss_p1      in   1  1-cycle pulse: ball left past left edge (point to P2)
//  miss_p2      in   1  1-cycle pulse: ball left past right edge (point to P1)
//  state        out  3  0 READY,1 SETTING,2 SERVE,3 PLAY,4 GAMEOVER
//  setting_sel  out  2  selected field in SETTING: 0 win,1 speed,2 time
//  score1       out  4  player 1 score
//  score2       out  4  player 2 score
//  seconds      out  7  remaining match seconds
//  win_score    out  4  points needed to win
//  ball_speed   out  4  speed passed to ball
//  time_limit   out  7  configured match length, seconds
//  new_round    out  1  1-cycle pulse: ball must re-centre
//  ball_en      out  1  1 only in PLAY; ball frozen otherwise
//  game_over    out  1  1 only in GAMEOVER
//  winner       out  2  01 P1, 10 P2, 11 draw, 00 none; valid in GAMEOVER
// BEHAVIOUR
//  Reset: state READY, sel 0, scores 0, win_score DEF_WIN, ball_speed DEF_SPEED,
//   time_limit DEF_TIME, seconds DEF_TIME, new_round/ball_en/game_over 0, winner 00.
//   Reset mid-match aborts immediately; settings return to defaults.
//  All outputs registered; response appears the cycle after the input pulse.
//  READY: enter -> SERVE, scores<=0, seconds<=time_limit, winner<=00, new_round=1.
//   Else up or down -> SETTING, sel<=0. Enter has priority over up/down.
//  SETTING: up/down adjust field sel by +/-1, saturating at legal limits;
//   up and down same cycle -> no change. enter: sel 0->1->2; enter at sel 2 -> READY,
//   sel<=0. Enter has priority over up/down.
//  SERVE: frame counter cleared on entry; after SERVE_FRAMES frame_ticks -> PLAY.
//   seconds frozen; miss pulses ignored.
//  PLAY: ball_en=1. Second prescaler counts frame_ticks; every FRAMES_PER_SEC-th
//   decrements seconds (never below 0). Prescaler cleared on entry to SERVE.
//   miss_p2 -> score1+1; miss_p1 -> score2+1; both same cycle -> miss_p1 only.
//   After a point: new score == win_score -> GAMEOVER, winner = scorer;
//   else -> SERVE with new_round=1. Scores never exceed win_score (no wrap).
//   seconds reaching 0 (no point same cycle) -> GAMEOVER; winner by higher score,
//   11 if equal. Point and expiry same cycle: point applied first; if it wins,
//   winner = scorer, else winner by score compare after the point.
//  GAMEOVER: game_over=1, ball_en=0, scores/winner held. enter, or OVER_FRAMES
//   frame_ticks, -> READY. Up/down ignored.
//  new_round also pulses on GAMEOVER->READY so the ball re-centres.
//  Frame counter 8-bit, cleared on each state entry; counts only in SERVE/GAMEOVER.
// TESTING
//  Reset then READY: check win 5, speed 2, limit 60, seconds 60, all flags 0.
//  SETTING: up x6 at sel0 -> win 9 (saturates); enter, down x3 -> speed 1;
//   enter, up x50 -> limit 99; enter -> READY.
//  Match: enter -> new_round 1 cycle, SERVE; 60 frame_ticks -> PLAY, ball_en 1;
//   miss_p2 x5 (win 5) -> score1 5, GAMEOVER, winner 01.
//  Timeout: limit 10, score 1-1, 600 frame_ticks in PLAY -> seconds 0, winner 11.
//  Simultaneous miss_p1+miss_p2 in PLAY -> only score2+1; point at seconds 0 -> won by scorer.
//  Async reset asserted during PLAY with score 3-2 -> READY, scores 0, ball_en 0 immediately.

Source files
------------

// File: rtl/match_ctrl.sv
// Match sequencer for two-player pong: top-level game FSM, scores, countdown
// timer and user settings. Every output is a register or a decode of state_q.
module match_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int SERVE_FRAMES   = 60,
  parameter int OVER_FRAMES    = 180,
  parameter int DEF_WIN        = 5,
  parameter int DEF_SPEED      = 2,
  parameter int DEF_TIME       = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enter_pulse,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic [2:0] state,
  output logic [1:0] setting_sel,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [6:0] seconds,
  output logic [3:0] win_score,
  output logic [3:0] ball_speed,
  output logic [6:0] time_limit,
  output logic       new_round,
  output logic       ball_en,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_READY = 3'd0, S_SETTING = 3'd1, S_SERVE = 3'd2, S_PLAY = 3'd3, S_OVER = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
  localparam logic [7:0] SEC_LAST   = 8'(FRAMES_PER_SEC - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic [6:0] seconds_q, seconds_d;
  logic [3:0] win_q, win_d, speed_q, speed_d;
  logic [6:0] limit_q, limit_d;
  logic       new_round_q, new_round_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] presc_q, presc_d;

  // Point and timer outcome of the current cycle, shared by both comb blocks.
  // miss_p1 wins when both misses arrive together.
  logic       in_play, point, p2_pt, win_pt, sec_tick, expire;
  logic [3:0] sc1_new, sc2_new;
  logic [6:0] sec_after;
  logic [1:0] cmp_winner;

  always_comb begin
    in_play    = (state_q == S_PLAY);
    point      = in_play && (miss_p1 || miss_p2);
    p2_pt      = miss_p1;
    sc1_new    = (point && !p2_pt) ? score1_q + 4'd1 : score1_q;
    sc2_new    = (point &&  p2_pt) ? score2_q + 4'd1 : score2_q;
    win_pt     = point && (p2_pt ? (sc2_new == win_q) : (sc1_new == win_q));
    sec_tick   = in_play && frame_tick && (presc_q == SEC_LAST);
    sec_after  = (sec_tick && seconds_q != 7'd0) ? seconds_q - 7'd1 : seconds_q;
    expire     = in_play && (sec_after == 7'd0);
    cmp_winner = (sc1_new > sc2_new) ? 2'b01 : (sc2_new > sc1_new) ? 2'b10 : 2'b11;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_READY;
      sel_q       <= 2'd0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      seconds_q   <= 7'(DEF_TIME);
      win_q       <= 4'(DEF_WIN);
      speed_q     <= 4'(DEF_SPEED);
      limit_q     <= 7'(DEF_TIME);
      new_round_q <= 1'b0;
      winner_q    <= 2'b00;
      frame_q     <= 8'd0;
      presc_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      seconds_q   <= seconds_d;
      win_q       <= win_d;
      speed_q     <= speed_d;
      limit_q     <= limit_d;
      new_round_q <= new_round_d;
      winner_q    <= winner_d;
      frame_q     <= frame_d;
      presc_q     <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READY:   if (enter_pulse) state_d = S_SERVE;
                 else if (up_pulse || down_pulse) state_d = S_SETTING;
      S_SETTING: if (enter_pulse && sel_q >= 2'd2) state_d = S_READY;
      S_SERVE:   if (frame_tick && frame_q == SERVE_LAST) state_d = S_PLAY;
      S_PLAY:    if (win_pt || expire) state_d = S_OVER;
                 else if (point) state_d = S_SERVE;
      S_OVER:    if (enter_pulse || (frame_tick && frame_q == OVER_LAST)) state_d = S_READY;
      default:   state_d = S_READY;
    endcase
  end

  always_comb begin
    sel_d       = sel_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    seconds_d   = seconds_q;
    win_d       = win_q;
    speed_d     = speed_q;
    limit_d     = limit_q;
    new_round_d = 1'b0;
    winner_d    = winner_q;
    presc_d     = presc_q;
    case (state_q)
      S_READY: begin
        if (enter_pulse) begin
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          seconds_d   = limit_q;
          winner_d    = 2'b00;
          new_round_d = 1'b1;
        end else if (up_pulse || down_pulse) begin
          sel_d = 2'd0;
        end
      end
      S_SETTING: begin
        if (enter_pulse) begin
          sel_d = (sel_q >= 2'd2) ? 2'd0 : sel_q + 2'd1;
        end else if (up_pulse != down_pulse) begin
          case (sel_q)
            2'd0: if (up_pulse && win_q < 4'd9) win_d = win_q + 4'd1;
                  else if (down_pulse && win_q > 4'd1) win_d = win_q - 4'd1;
            2'd1: if (up_pulse && speed_q < 4'd15) speed_d = speed_q + 4'd1;
                  else if (down_pulse && speed_q > 4'd1) speed_d = speed_q - 4'd1;
            default: if (up_pulse && limit_q < 7'd99) limit_d = limit_q + 7'd1;
                  else if (down_pulse && limit_q > 7'd10) limit_d = limit_q - 7'd1;
          endcase
        end
      end
      S_PLAY: begin
        score1_d  = sc1_new;
        score2_d  = sc2_new;
        seconds_d = sec_after;
        if (frame_tick) presc_d = (presc_q == SEC_LAST) ? 8'd0 : presc_q + 8'd1;
        if (win_pt)      winner_d = p2_pt ? 2'b10 : 2'b01;
        else if (expire) winner_d = cmp_winner;
        if (state_d == S_SERVE) new_round_d = 1'b1;
      end
      S_OVER: if (state_d == S_READY) new_round_d = 1'b1;
      default: ;
    endcase
    // Prescaler restarts with every serve so each rally begins on a full second.
    if (state_d == S_SERVE && state_q != S_SERVE) presc_d = 8'd0;
  end

  always_comb begin
    frame_d = frame_q;
    if (state_d != state_q) frame_d = 8'd0;
    else if (frame_tick && (state_q == S_SERVE || state_q == S_OVER)) frame_d = frame_q + 8'd1;
  end

  assign state       = state_q;
  assign setting_sel = sel_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign seconds     = seconds_q;
  assign win_score   = win_q;
  assign ball_speed  = speed_q;
  assign time_limit  = limit_q;
  assign new_round   = new_round_q;
  assign winner      = winner_q;
  assign ball_en     = (state_q == S_PLAY);
  assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl: settings, full match, timeout, simultaneous
// miss, point at expiry and asynchronous abort.
module tb_match_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic       frame_tick = 0, enter_pulse = 0, up_pulse = 0, down_pulse = 0;
  logic       miss_p1 = 0, miss_p2 = 0;
  logic [2:0] state;
  logic [1:0] setting_sel, winner;
  logic [3:0] score1, score2, win_score, ball_speed;
  logic [6:0] seconds, time_limit;
  logic       new_round, ball_en, game_over;

  int npass = 0, ntot = 0;

  localparam logic [5:0] EN = 6'b100000, UP = 6'b010000, DN = 6'b001000,
                         M1 = 6'b000100, M2 = 6'b000010, FT = 6'b000001;

  match_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enter_pulse(enter_pulse),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .miss_p1(miss_p1), .miss_p2(miss_p2),
    .state(state), .setting_sel(setting_sel), .score1(score1), .score2(score2),
    .seconds(seconds), .win_score(win_score), .ball_speed(ball_speed),
    .time_limit(time_limit), .new_round(new_round), .ball_en(ball_en),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One-cycle pulse driven on the falling edge; returns on the next falling edge,
  // so outputs are sampled half a cycle after the edge that consumed the pulse.
  task automatic pulse(input logic [5:0] v);
    @(negedge clk);
    {enter_pulse, up_pulse, down_pulse, miss_p1, miss_p2, frame_tick} = v;
    @(negedge clk);
    {enter_pulse, up_pulse, down_pulse, miss_p1, miss_p2, frame_tick} = 6'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) pulse(FT);
  endtask

  task automatic pulses(input logic [5:0] v, input int n);
    repeat (n) pulse(v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("state_in_reset", state, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_sel", setting_sel, 0);
    chk("rst_score1", score1, 0);
    chk("rst_score2", score2, 0);
    chk("rst_win", win_score, 5);
    chk("rst_speed", ball_speed, 2);
    chk("rst_limit", time_limit, 60);
    chk("rst_seconds", seconds, 60);
    chk("rst_flags", {new_round, ball_en, game_over}, 0);
    chk("rst_winner", winner, 0);

    // settings
    pulse(UP);
    chk("set_enter_state", state, 1);
    chk("set_enter_win", win_score, 5);
    pulses(UP, 6);
    chk("win_sat", win_score, 9);
    pulse(EN);
    chk("sel1", setting_sel, 1);
    pulses(DN, 3);
    chk("speed_sat", ball_speed, 1);
    pulse(UP | DN);
    chk("updown_nochange", ball_speed, 1);
    pulse(EN | UP);
    chk("sel2_enter_prio", setting_sel, 2);
    chk("enter_prio_speed", ball_speed, 1);
    pulses(UP, 50);
    chk("limit_sat", time_limit, 99);
    pulse(EN);
    chk("set_exit_state", state, 0);
    chk("set_exit_sel", setting_sel, 0);
    chk("seconds_kept", seconds, 60);

    // reset restores defaults
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst2_win", win_score, 5);
    chk("rst2_speed", ball_speed, 2);
    chk("rst2_limit", time_limit, 99 - 39);

    // match to 5 points for P1
    pulse(EN | UP);
    chk("serve_state", state, 2);
    chk("serve_new_round", new_round, 1);
    @(negedge clk);
    chk("new_round_1cyc", new_round, 0);
    pulse(M2);
    chk("serve_miss_ignored", score1, 0);
    frames(59);
    chk("serve_hold59", state, 2);
    chk("serve_ball_off", ball_en, 0);
    frames(1);
    chk("play_state", state, 3);
    chk("play_ball_en", ball_en, 1);
    for (int i = 1; i <= 5; i++) begin
      pulse(M2);
      chk("p1_point", score1, i);
      if (i < 5) begin
        chk("point_to_serve", state, 2);
        chk("point_new_round", new_round, 1);
        frames(60);
      end
    end
    chk("win_state", state, 4);
    chk("win_game_over", game_over, 1);
    chk("win_ball_en", ball_en, 0);
    chk("win_winner", winner, 2'b01);
    chk("win_score2", score2, 0);
    pulse(UP);
    chk("over_up_ignored", state, 4);
    pulse(EN);
    chk("over_enter_ready", state, 0);
    chk("over_new_round", new_round, 1);
    chk("winner_held", winner, 2'b01);

    // timeout at limit 10 with 1-1
    pulse(UP); pulse(EN); pulse(EN);
    pulses(DN, 50);
    chk("limit_min", time_limit, 10);
    pulse(EN);
    pulse(EN);
    chk("seconds_loaded", seconds, 10);
    chk("scores_cleared", score1, 0);
    frames(60); pulse(M2);
    frames(60); pulse(M1);
    chk("tie_s1", score1, 1);
    chk("tie_s2", score2, 1);
    frames(60);
    chk("tie_play", state, 3);
    frames(599);
    chk("sec_before_exp", seconds, 1);
    chk("play_before_exp", state, 3);
    frames(1);
    chk("sec_expired", seconds, 0);
    chk("exp_state", state, 4);
    chk("exp_draw", winner, 2'b11);
    frames(179);
    chk("over_hold179", state, 4);
    frames(1);
    chk("over_auto_ready", state, 0);
    chk("auto_new_round", new_round, 1);

    // simultaneous misses, then point on the expiry tick
    pulse(EN);
    chk("winner_cleared", winner, 0);
    frames(60);
    pulse(M1 | M2);
    chk("both_s1", score1, 0);
    chk("both_s2", score2, 1);
    frames(60);
    frames(599);
    pulse(FT | M1);
    chk("pexp_s2", score2, 2);
    chk("pexp_sec", seconds, 0);
    chk("pexp_state", state, 4);
    chk("pexp_winner", winner, 2'b10);

    // abort mid-play at 3-2
    pulse(EN);
    pulse(EN);
    for (int i = 0; i < 5; i++) begin
      frames(60);
      pulse((i % 2 == 0) ? M2 : M1);
    end
    frames(60);
    chk("abort_pre_s1", score1, 3);
    chk("abort_pre_s2", score2, 2);
    chk("abort_pre_play", ball_en, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_state", state, 0);
    chk("abort_s1", score1, 0);
    chk("abort_s2", score2, 0);
    chk("abort_ball_en", ball_en, 0);
    chk("abort_limit", time_limit, 60);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("after_abort_state", state, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
